// File: rtl/mac_sm_normalize.sv
// mac_sm_normalize: two's-complement to sign-magnitude conversion with mantissa normalization, 2-stage valid/ready pipeline
module mac_sm_normalize #(
    parameter int IN_WIDTH   = 24,
    parameter int MANT_WIDTH = 10,
    parameter int EXP_WIDTH  = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic [EXP_WIDTH-1:0] i_exp,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign,
    output logic [MANT_WIDTH-1:0] o_mant,
    output logic [EXP_WIDTH-1:0] o_exp,
    output logic                 o_zero,
    output logic                 o_inexact,
    output logic                 o_exp_sat
);
    localparam int PW = $clog2(IN_WIDTH) + 1;
    localparam int EW = EXP_WIDTH + PW + 2;
    localparam logic [IN_WIDTH-1:0] LOW_MASK = {IN_WIDTH{1'b1}} >> MANT_WIDTH;
    localparam logic signed [EW-1:0] EMAX = EW'((1 << (EXP_WIDTH-1)) - 1);
    localparam logic signed [EW-1:0] EMIN = ~EMAX;

    logic                 s1_valid, s1_sign;
    logic [IN_WIDTH-1:0]  s1_mag;
    logic [EXP_WIDTH-1:0] s1_exp;
    logic                 s2_load, in_sign, zero, sat_hi, sat_lo;
    logic [IN_WIDTH-1:0]  in_mag, norm;
    logic [PW-1:0]        p;
    logic signed [EW-1:0] te;
    logic [EXP_WIDTH-1:0] exp_out;

    assign s2_load = !o_valid || i_ready;
    assign o_ready = !s1_valid || s2_load;
    assign in_sign = i_data[IN_WIDTH-1];
    assign in_mag  = in_sign ? ~i_data + IN_WIDTH'(1) : i_data;

    always_comb begin
        p = '0;
        for (int i = 0; i < IN_WIDTH; i++) p = s1_mag[i] ? PW'(i) : p;
        norm    = s1_mag << (PW'(IN_WIDTH-1) - p);
        zero    = s1_mag == '0;
        // guard bits keep the true exponent from wrapping before the clamp check
        te      = EW'($signed(s1_exp)) + EW'(p) - EW'(MANT_WIDTH-1);
        sat_hi  = !zero && te > EMAX;
        sat_lo  = !zero && te < EMIN;
        exp_out = zero ? '0 :
                  sat_hi ? {1'b0, {(EXP_WIDTH-1){1'b1}}} :
                  sat_lo ? {1'b1, {(EXP_WIDTH-1){1'b0}}} : te[EXP_WIDTH-1:0];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_exp   <= '0;
        end else if (o_ready) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sign <= in_sign;
                s1_mag  <= in_mag;
                s1_exp  <= i_exp;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid   <= 1'b0;
            o_sign    <= 1'b0;
            o_mant    <= '0;
            o_exp     <= '0;
            o_zero    <= 1'b0;
            o_inexact <= 1'b0;
            o_exp_sat <= 1'b0;
        end else if (s2_load) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_sign    <= s1_sign && !zero;
                o_mant    <= norm[IN_WIDTH-1 -: MANT_WIDTH];
                o_exp     <= exp_out;
                o_zero    <= zero;
                o_inexact <= |(norm & LOW_MASK);
                o_exp_sat <= sat_hi || sat_lo;
            end
        end
    end
endmodule

// File: tb/tb_mac_sm_normalize.sv
// tb_mac_sm_normalize: directed self-checking bench for mac_sm_normalize
module tb_mac_sm_normalize;
    logic        clk = 1'b0;
    logic        rst, i_valid, i_ready, o_ready, o_valid;
    logic [23:0] i_data;
    logic [5:0]  i_exp, o_exp;
    logic        o_sign, o_zero, o_inexact, o_exp_sat;
    logic [9:0]  o_mant;
    int          vectors = 0;
    int          miscompares = 0;

    mac_sm_normalize dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_exp(i_exp), .o_valid(o_valid), .i_ready(i_ready),
        .o_sign(o_sign), .o_mant(o_mant), .o_exp(o_exp), .o_zero(o_zero),
        .o_inexact(o_inexact), .o_exp_sat(o_exp_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        vectors++;
        assert (got === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one beat with i_ready high; result must show up exactly two edges later
    task automatic beat(input string tag, input logic [23:0] d, input logic [5:0] e,
                        input logic s, input logic [9:0] m, input logic [5:0] oe,
                        input logic z, input logic ix, input logic sat);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = d;
        i_exp   = e;
        step();
        i_valid = 1'b0;
        chk({tag, "_lat1"}, o_valid, 0);
        step();
        chk({tag, "_valid"}, o_valid, 1);
        chk({tag, "_out"}, {o_sign, o_mant, o_exp, o_zero, o_inexact, o_exp_sat},
            {s, m, oe, z, ix, sat});
        step();
        chk({tag, "_drain"}, o_valid, 0);
    endtask

    logic [9:0] bp_mant [8] = '{10'h200, 10'h200, 10'h300, 10'h200, 10'h280, 10'h300, 10'h380, 10'h200};
    logic [5:0] bp_exp  [8] = '{6'h37, 6'h38, 6'h38, 6'h39, 6'h39, 6'h39, 6'h39, 6'h3A};

    initial begin
        int sent, got;
        logic stalled, saw_full;
        logic [16:0] held;
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data = '0; i_exp = '0;
        #3;
        chk("rst_state", {o_valid, o_sign, o_mant, o_exp, o_zero, o_inexact, o_exp_sat}, 0);
        chk("rst_ready", o_ready, 1);
        rst = 1'b0;
        step();

        beat("pos",     24'h000300, 6'h00, 0, 10'h300, 6'h00, 0, 0, 0);
        beat("neg",     24'hFFFD00, 6'h00, 1, 10'h300, 6'h00, 0, 0, 0);
        beat("most_neg",24'h800000, 6'h00, 1, 10'h200, 6'h0E, 0, 0, 0);
        beat("small",   24'h000001, 6'h3D, 0, 10'h200, 6'h34, 0, 0, 0);
        beat("inexact", 24'h000C01, 6'h00, 0, 10'h300, 6'h02, 0, 1, 0);
        beat("zero",    24'h000000, 6'h05, 0, 10'h000, 6'h00, 1, 0, 0);
        beat("sat_hi",  24'h800000, 6'h1F, 1, 10'h200, 6'h1F, 0, 0, 1);
        beat("sat_lo",  24'h000001, 6'h20, 0, 10'h200, 6'h20, 0, 0, 1);
        beat("neg_one", 24'hFFFFFF, 6'h00, 1, 10'h200, 6'h37, 0, 0, 0);

        // backpressure: 8 beats, i_ready low during cycles 3..5
        sent = 0; got = 0; stalled = 0; saw_full = 0; held = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            i_ready = !(c >= 3 && c <= 5);
            i_valid = sent < 8;
            i_data  = 24'(sent + 1);
            i_exp   = '0;
            #1;
            if (stalled) chk("bp_hold", {o_sign, o_mant, o_exp}, held);
            if (!o_ready) saw_full = 1;
            if (o_valid && i_ready) begin
                chk("bp_data", {o_sign, o_mant, o_exp, o_inexact}, {1'b0, bp_mant[got], bp_exp[got], 1'b0});
                got++;
            end
            stalled = o_valid && !i_ready;
            held    = {o_sign, o_mant, o_exp};
            if (i_valid && o_ready) sent++;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("bp_count", got, 8);
        chk("bp_ready_drop", saw_full, 1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_no_extra", o_valid, 0);
        end

        // asynchronous reset with two beats in flight
        i_valid = 1'b1; i_data = 24'h000100; i_exp = '0;
        step();
        i_data = 24'h000200;
        step();
        i_valid = 1'b0;
        chk("rst_pre_valid", o_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", o_valid, 0);
        chk("rst_async_ready", o_ready, 1);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rst_no_stale", o_valid, 0);
        end
        chk("rst_final_ready", o_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
